// File: rtl/crc_code_pkg.sv
// Shared constants and buffer state encoding for the CRC codeword builder
// and the matching read-path checker.
package crc_code_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_CRC_WIDTH  = 4;
    localparam logic [DEF_CRC_WIDTH-1:0] DEF_POLY = 4'h3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/crc_codeword_builder_crc_lfsr_step.sv
// Single-bit long-division remainder update: shifts one message bit into the
// remainder and folds in the generator when the outgoing MSB is set.
module crc_lfsr_step #(
    parameter int unsigned           CRC_WIDTH = 4,
    parameter logic [CRC_WIDTH-1:0]  POLY      = 4'h3
) (
    input  logic [CRC_WIDTH-1:0] rem,
    input  logic                 in_bit,
    output logic [CRC_WIDTH-1:0] rem_next_c
);

    always_comb begin
        rem_next_c = {rem[CRC_WIDTH-2:0], in_bit};
        if (rem[CRC_WIDTH-1]) begin
            rem_next_c = rem_next_c ^ POLY;
        end
    end

endmodule

// File: rtl/crc_codeword_builder.sv
// Bit-serial CRC datapath with a one-entry valid/ready codeword buffer.
// Optional shift-count checking is enabled by defining CRC_CODEWORD_SEQ_CHECK_EN.
module crc_codeword_builder
    import crc_code_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned          CRC_WIDTH  = DEF_CRC_WIDTH,
    parameter logic [CRC_WIDTH-1:0] POLY       = CRC_WIDTH'(DEF_POLY)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_en,
    input  logic                            shift_en,
    input  logic                            data_valid,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            cw_ready,
    output logic [DATA_WIDTH+CRC_WIDTH-1:0] cw_data,
    output logic                            cw_valid,
    output logic                            overflow,
    output logic                            seq_err
);

    localparam int unsigned CW_WIDTH = DATA_WIDTH + CRC_WIDTH;

    logic [CW_WIDTH-1:0]   msg_q, msg_d;
    logic [DATA_WIDTH-1:0] data_snap_q, data_snap_d;
    logic [CRC_WIDTH-1:0]  rem_q, rem_d, rem_step_c;
    buf_state_e            buf_state_q, buf_state_d;
    logic [CW_WIDTH-1:0]   cw_data_q, cw_data_d;
    logic                  cw_valid_q, cw_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  seq_err_q, seq_err_d;

    crc_lfsr_step #(
        .CRC_WIDTH (CRC_WIDTH),
        .POLY      (POLY)
    ) u_step (
        .rem        (rem_q),
        .in_bit     (msg_q[CW_WIDTH-1]),
        .rem_next_c (rem_step_c)
    );

    // Message/remainder datapath; shift wins over a coincident load.
    always_comb begin
        msg_d       = msg_q;
        data_snap_d = data_snap_q;
        rem_d       = rem_q;
        if (shift_en) begin
            msg_d = msg_q << 1;
            rem_d = rem_step_c;
        end else if (load_en) begin
            msg_d       = {data_in, {CRC_WIDTH{1'b0}}};
            data_snap_d = data_in;
            rem_d       = '0;
        end
    end

`ifdef CRC_CODEWORD_SEQ_CHECK_EN
    localparam int unsigned CNT_W = $clog2(CW_WIDTH + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seq_bad_c;

    always_comb begin
        cnt_d = cnt_q;
        if (shift_en) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (load_en) begin
            cnt_d = '0;
        end
    end

    assign seq_bad_c = (cnt_q != CNT_W'(CW_WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic seq_bad_c;
    assign seq_bad_c = 1'b0;
`endif

    // Buffer FSM and sticky flags.
    always_comb begin
        buf_state_d = buf_state_q;
        cw_data_d   = cw_data_q;
        overflow_d  = overflow_q;
        seq_err_d   = seq_err_q;
        if (data_valid && seq_bad_c) begin
            seq_err_d = 1'b1;
        end
        case (buf_state_q)
            EMPTY: begin
                if (data_valid) begin
                    cw_data_d   = {data_snap_q, rem_q};
                    buf_state_d = FULL;
                end
            end
            FULL: begin
                if (data_valid) begin
                    if (cw_ready) begin
                        cw_data_d = {data_snap_q, rem_q};
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (cw_ready) begin
                    buf_state_d = EMPTY;
                end
            end
            default: buf_state_d = EMPTY;
        endcase
        cw_valid_d = (buf_state_d == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_q       <= '0;
            data_snap_q <= '0;
            rem_q       <= '0;
            buf_state_q <= EMPTY;
            cw_data_q   <= '0;
            cw_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            msg_q       <= msg_d;
            data_snap_q <= data_snap_d;
            rem_q       <= rem_d;
            buf_state_q <= buf_state_d;
            cw_data_q   <= cw_data_d;
            cw_valid_q  <= cw_valid_d;
            overflow_q  <= overflow_d;
            seq_err_q   <= seq_err_d;
        end
    end

    assign cw_data  = cw_data_q;
    assign cw_valid = cw_valid_q;
    assign overflow = overflow_q;
    assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_crc_codeword_builder.sv
// Directed bench for crc_codeword_builder; expected codewords are hand-computed
// for x^4+x+1 (A5 -> A5B, 01 -> 013, 00 -> 000, A5 after 11 shifts -> A5C).
module tb_crc_codeword_builder;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en, shift_en, data_valid, cw_ready;
    logic [7:0]  data_in;
    logic [11:0] cw_data;
    logic        cw_valid, overflow, seq_err;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    crc_codeword_builder dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .shift_en   (shift_en),
        .data_valid (data_valid),
        .data_in    (data_in),
        .cw_ready   (cw_ready),
        .cw_data    (cw_data),
        .cw_valid   (cw_valid),
        .overflow   (overflow),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load, n shifts, one data_valid pulse; returns on the negedge after data_valid.
    task automatic encode(input logic [7:0] d, input int n, input logic rdy_at_dv);
        @(negedge clk);
        load_en = 1'b1;
        data_in = d;
        @(negedge clk);
        load_en  = 1'b0;
        shift_en = 1'b1;
        repeat (n) @(negedge clk);
        shift_en   = 1'b0;
        data_valid = 1'b1;
        if (rdy_at_dv) cw_ready = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        if (rdy_at_dv) cw_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic exp_seq;

    initial begin
        rst = 1'b1; load_en = 1'b0; shift_en = 1'b0; data_valid = 1'b0;
        cw_ready = 1'b0; data_in = '0;
        @(negedge clk);
        check("rst_cw_data",  32'(cw_data),  32'h0);
        check("rst_cw_valid", 32'(cw_valid), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_seq_err",  32'(seq_err),  32'h0);
        rst = 1'b0;

        // Streaming with ready held high: each codeword visible for one cycle.
        cw_ready = 1'b1;
        encode(8'hA5, 12, 1'b0);
        check("a5_valid", 32'(cw_valid), 32'h1);
        check("a5_data",  32'(cw_data),  32'hA5B);
        check("a5_seq",   32'(seq_err),  32'h0);
        @(negedge clk);
        check("a5_valid_drop", 32'(cw_valid), 32'h0);

        encode(8'h01, 12, 1'b0);
        check("01_valid", 32'(cw_valid), 32'h1);
        check("01_data",  32'(cw_data),  32'h013);
        @(negedge clk);
        check("01_valid_drop", 32'(cw_valid), 32'h0);

        encode(8'h00, 12, 1'b0);
        check("00_valid", 32'(cw_valid), 32'h1);
        check("00_data",  32'(cw_data),  32'h000);
        @(negedge clk);
        check("00_valid_drop", 32'(cw_valid), 32'h0);

        // Back-to-back with ready low: second codeword dropped.
        cw_ready = 1'b0;
        encode(8'hA5, 12, 1'b0);
        check("ovf_first_valid", 32'(cw_valid), 32'h1);
        check("ovf_first_flag",  32'(overflow), 32'h0);
        encode(8'h01, 12, 1'b0);
        check("ovf_held_data", 32'(cw_data),  32'hA5B);
        check("ovf_valid",     32'(cw_valid), 32'h1);
        check("ovf_flag",      32'(overflow), 32'h1);
        cw_ready = 1'b1;
        @(negedge clk);
        check("ovf_drain_valid", 32'(cw_valid), 32'h0);
        check("ovf_sticky",      32'(overflow), 32'h1);

        do_reset();
        check("rst2_overflow", 32'(overflow), 32'h0);

        // Full buffer replaced by a coincident data_valid + ready.
        cw_ready = 1'b0;
        encode(8'h01, 12, 1'b0);
        check("rep_old_data", 32'(cw_data), 32'h013);
        encode(8'hA5, 12, 1'b1);
        check("rep_valid", 32'(cw_valid), 32'h1);
        check("rep_data",  32'(cw_data),  32'hA5B);
        check("rep_ovf",   32'(overflow), 32'h0);
        cw_ready = 1'b1;
        @(negedge clk);
        check("rep_drain", 32'(cw_valid), 32'h0);

        // Asynchronous reset mid-shift with a full buffer.
        cw_ready = 1'b0;
        encode(8'h01, 12, 1'b0);
        @(negedge clk);
        load_en = 1'b1; data_in = 8'hA5;
        @(negedge clk);
        load_en = 1'b0; shift_en = 1'b1;
        repeat (5) @(negedge clk);
        shift_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("amid_valid", 32'(cw_valid), 32'h0);
        check("amid_data",  32'(cw_data),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        cw_ready = 1'b1;
        encode(8'hA5, 12, 1'b0);
        check("post_rst_data",  32'(cw_data),  32'hA5B);
        check("post_rst_valid", 32'(cw_valid), 32'h1);
        check("post_rst_ovf",   32'(overflow), 32'h0);
        check("post_rst_seq",   32'(seq_err),  32'h0);
        @(negedge clk);

        // Short shift sequence.
`ifdef CRC_CODEWORD_SEQ_CHECK_EN
        exp_seq = 1'b1;
`else
        exp_seq = 1'b0;
`endif
        encode(8'hA5, 11, 1'b0);
        check("short_valid", 32'(cw_valid), 32'h1);
        check("short_data",  32'(cw_data),  32'hA5C);
        check("short_seq",   32'(seq_err),  32'(exp_seq));
        @(negedge clk);
        check("short_drain", 32'(cw_valid), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/crc_codeword_builder.md
# crc_codeword_builder

Bit-serial CRC datapath and codeword output buffer, directly downstream of the CRC sequencing controller. It consumes the controller's `load_en`, `shift_en` and `data_valid` strobes and runs a long-division LFSR over the augmented message. It then presents the resulting codeword `{data, crc}` to the memory write path through a one-entry valid/ready buffer.

## Interface
- DATA_WIDTH, 8, message width in bits
- CRC_WIDTH, 4, remainder width in bits
- POLY, 4'h3, generator polynomial without the implicit top term (x^4+x+1); width CRC_WIDTH
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- load_en  input  1  controller strobe; capture `data_in` and clear the remainder
- shift_en  input  1  controller strobe; advance the LFSR by one message bit
- data_valid  input  1  controller one-cycle pulse; remainder final, capture codeword
- data_in  input  DATA_WIDTH  message to encode, sampled while `load_en` is high
- cw_ready  input  1  downstream accepts codeword
- cw_data  output  DATA_WIDTH+CRC_WIDTH  codeword `{data, crc}`; data in the MSBs
- cw_valid  output  1  `cw_data` holds an unconsumed codeword
- overflow  output  1  sticky: a codeword was dropped because the buffer was full
- seq_err  output  1  sticky: shift count at `data_valid` was not DATA_WIDTH+CRC_WIDTH (see Configuration)

## Operation
- Internal registers:
  - `msg`: DATA_WIDTH+CRC_WIDTH bit shift register.
  - `data_snap`: DATA_WIDTH bits.
  - `rem`: CRC_WIDTH bits.
  - `buf_state` ∈ {EMPTY, FULL}.
- `load_en` high (and `shift_en` low):
  - `msg <= {data_in, CRC_WIDTH'b0}`
  - `data_snap <= data_in`
  - `rem <= 0`
  - Shift counter cleared.
  - Repeats every cycle the strobe is high; the last sampled value wins.
- `shift_en` high:
  - `in = msg[MSB]`
  - `fb = rem[CRC_WIDTH-1]`
  - `rem <= {rem[CRC_WIDTH-2:0], in} ^ (fb ? POLY : 0)`
  - `msg <= msg << 1`
  - Shift counter increments.
- `load_en` and `shift_en` both high: shift takes priority, load ignored.
- Required shift count: exactly DATA_WIDTH+CRC_WIDTH shifts (12 at defaults). The controller delivers NUM_CYCLES+1 = 12 shift cycles.
- `data_valid` pulse: codeword `{data_snap, rem}` is offered to the buffer.
  - EMPTY: codeword is loaded; state becomes FULL.
  - FULL with `cw_ready` high in the same cycle: old codeword is consumed and the new one is loaded; state stays FULL; no overflow.
  - FULL with `cw_ready` low: new codeword is dropped, `overflow <= 1`, held codeword unchanged.
- Buffer with no `data_valid`: FULL && `cw_ready` → EMPTY.
- `cw_data` is stable while `cw_valid` is high and `cw_ready` is low.
- Sticky flags clear only on `rst`.

## Timing
- Reset values: `cw_data` = 0, `cw_valid` = 0, `overflow` = 0, `seq_err` = 0; internal `msg`/`data_snap`/`rem`/counter = 0; `buf_state` = EMPTY.
- Latency: `cw_valid` rises the cycle after the `data_valid` pulse. End to end, that is DATA_WIDTH+CRC_WIDTH+2 cycles after the last `load_en` cycle.
- Handshake: transfer occurs on a rising edge where `cw_valid && cw_ready`. `cw_valid` falls the next cycle unless a simultaneous `data_valid` reloads the buffer.
- `cw_ready` may be high while `cw_valid` is low; this has no effect.
- `rst` mid-shift or with the buffer FULL: all state is cleared immediately (asynchronous). The pending codeword is discarded and no flag is set.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `CRC_CODEWORD_SEQ_CHECK_EN` defined:
  - A shift counter of `$clog2(DATA_WIDTH+CRC_WIDTH+1)` bits saturates at its maximum.
  - On `data_valid`, if counter ≠ DATA_WIDTH+CRC_WIDTH, `seq_err <= 1`. The codeword is still buffered.
- Not defined: counter is absent and `seq_err` is tied to 0.

## Structure
- Shared package `crc_code_pkg`: default DATA_WIDTH, CRC_WIDTH, POLY constants; `buf_state` enum (EMPTY, FULL).
- One sub-module, `crc_lfsr_step`: combinational single-bit remainder update (rem, in, POLY → next rem), reusable by the CRC checker on the read path.
- Buffer FSM and sticky flags stay in the top module.

## Test plan
- `data_in` = 8'hA5; load, 12 shifts, `data_valid` → next cycle `cw_valid` = 1, `cw_data` = 12'hA5B, `seq_err` = 0.
- `data_in` = 8'h01 → 12'h013. `data_in` = 8'h00 → 12'h000. `cw_ready` held high; `cw_valid` is high for exactly one cycle each.
- `cw_ready` low, two back-to-back encodes (8'hA5 then 8'h01) → `cw_data` stays 12'hA5B, `overflow` = 1. Raise `cw_ready` → 12'hA5B transfers, then `cw_valid` = 0.
- FULL with `data_valid` and `cw_ready` high in the same cycle → new codeword replaces the old, `cw_valid` stays 1, `overflow` = 0.
- `rst` asserted after 5 shifts, then a clean 8'hA5 encode → 12'hA5B and all flags 0.
- With `CRC_CODEWORD_SEQ_CHECK_EN`: 11 shifts then `data_valid` → `seq_err` = 1 and a codeword is still presented. Without the macro, `seq_err` stays 0.
